// File: rtl/cache_pkg.sv
// Shared types, geometry constants and address-field helpers for the write-back,
// direct-mapped cache controller.
package cache_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 10;
   localparam int unsigned LINES    = 4;
   localparam int unsigned WORDS    = 4;
   localparam int unsigned CNT_W    = 16;

   localparam int unsigned WADDR_W  = ADDR_W - 2;
   localparam int unsigned OFFSET_W = $clog2(WORDS);
   localparam int unsigned INDEX_W  = $clog2(LINES);
   localparam int unsigned TAG_W    = WADDR_W - OFFSET_W - INDEX_W;

   typedef enum logic [2:0] {
      StIdle,
      StCompare,
      StWriteback,
      StAllocate,
      StResp
   } state_e;

   typedef logic [WADDR_W-1:0] waddr_t;

   // Helpers operate on the word address (byte address without bits [1:0]).
   function automatic logic [OFFSET_W-1:0] word_offset(input waddr_t waddr);
      return waddr[OFFSET_W-1:0];
   endfunction

   function automatic logic [INDEX_W-1:0] word_index(input waddr_t waddr);
      return waddr[OFFSET_W +: INDEX_W];
   endfunction

   function automatic logic [TAG_W-1:0] word_tag(input waddr_t waddr);
      return waddr[WADDR_W-1 -: TAG_W];
   endfunction

endpackage

// File: rtl/cache_ctrl_wb_dm_if.sv
// CPU-side request/response and memory-side burst signals of the cache controller.
// slave: the controller; master: the environment (requester plus memory).
interface cache_ctrl_wb_dm_if;
   import cache_pkg::*;

   logic               cpu_req;
   logic               cpu_we;
   logic [ADDR_W-1:0]  cpu_addr;
   logic [DATA_W-1:0]  cpu_wdata;
   logic               cpu_ready;
   logic [DATA_W-1:0]  cpu_rdata;
   logic               cpu_hit;

   logic               mem_req;
   logic               mem_we;
   logic [WADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0]  mem_wdata;
   logic [DATA_W-1:0]  mem_rdata;
   logic               mem_ack;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ready, cpu_rdata, cpu_hit,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ready, cpu_rdata, cpu_hit,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/cache_line_store.sv
// Tag/valid/dirty/data storage for the direct-mapped cache: one combinational read port
// and one write port addressed by line index and word offset.
module cache_line_store
   import cache_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [INDEX_W-1:0]  idx_i,
   input  logic [OFFSET_W-1:0] word_i,
   input  logic                word_we_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic                line_we_i,
   input  logic [TAG_W-1:0]    tag_i,
   input  logic                dirty_set_i,
   input  logic                dirty_clr_i,
   output logic [DATA_W-1:0]   rdata_o,
   output logic [TAG_W-1:0]    tag_o,
   output logic                valid_o,
   output logic                dirty_o
);

   logic [DATA_W-1:0] data_q [LINES][WORDS];
   logic [DATA_W-1:0] data_d [LINES][WORDS];
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [TAG_W-1:0]  tag_d  [LINES];
   logic [LINES-1:0]  valid_q, valid_d;
   logic [LINES-1:0]  dirty_q, dirty_d;

   always_comb begin
      data_d  = data_q;
      tag_d   = tag_q;
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (word_we_i) begin
         data_d[idx_i][word_i] = wdata_i;
      end
      // A line write installs a freshly filled, clean line.
      if (line_we_i) begin
         tag_d[idx_i]   = tag_i;
         valid_d[idx_i] = 1'b1;
      end
      if (line_we_i || dirty_clr_i) begin
         dirty_d[idx_i] = 1'b0;
      end else if (dirty_set_i) begin
         dirty_d[idx_i] = 1'b1;
      end
   end

   // Data and tags carry no reset; valid/dirty do.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      tag_q  <= tag_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   assign rdata_o = data_q[idx_i][word_i];
   assign tag_o   = tag_q[idx_i];
   assign valid_o = valid_q[idx_i];
   assign dirty_o = dirty_q[idx_i];

endmodule

// File: rtl/cache_ctrl_wb_dm.sv
// Write-back, direct-mapped cache controller: request latch, lookup/write-back/allocate
// FSM with a burst counter, and saturating hit/miss statistics.
module cache_ctrl_wb_dm
   import cache_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   cache_ctrl_wb_dm_if.slave    bus,
   output logic [CNT_W-1:0]     hit_cnt,
   output logic [CNT_W-1:0]     miss_cnt
);

   state_e              state_q, state_d;
   logic [OFFSET_W-1:0] cnt_q, cnt_d;
   logic                we_q, we_d;
   waddr_t              addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                miss_q, miss_d;
   logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

   logic [OFFSET_W-1:0] st_word;
   logic                st_word_we;
   logic [DATA_W-1:0]   st_wdata;
   logic                st_line_we;
   logic                st_dirty_set;
   logic                st_dirty_clr;
   logic [DATA_W-1:0]   st_rdata;
   logic [TAG_W-1:0]    st_tag;
   logic                st_valid;
   logic                st_dirty;

   logic [INDEX_W-1:0]  idx;
   logic [TAG_W-1:0]    tag;
   logic                lookup_hit;
   logic                beat;
   logic                last_beat;

   assign idx        = word_index(addr_q);
   assign tag        = word_tag(addr_q);
   assign lookup_hit = st_valid && (st_tag == tag);
   assign beat       = bus.mem_req && bus.mem_ack;
   assign last_beat  = beat && (cnt_q == OFFSET_W'(WORDS - 1));

   cache_line_store u_store (
      .clk         (clk),
      .rst_n       (rst_n),
      .idx_i       (idx),
      .word_i      (st_word),
      .word_we_i   (st_word_we),
      .wdata_i     (st_wdata),
      .line_we_i   (st_line_we),
      .tag_i       (tag),
      .dirty_set_i (st_dirty_set),
      .dirty_clr_i (st_dirty_clr),
      .rdata_o     (st_rdata),
      .tag_o       (st_tag),
      .valid_o     (st_valid),
      .dirty_o     (st_dirty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         miss_q     <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         miss_q     <= miss_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:      if (bus.cpu_req) state_d = StCompare;
         StCompare: begin
            if (lookup_hit)                state_d = StResp;
            else if (st_valid && st_dirty) state_d = StWriteback;
            else                           state_d = StAllocate;
         end
         StWriteback: if (last_beat) state_d = StAllocate;
         StAllocate:  if (last_beat) state_d = StCompare;
         StResp:      state_d = StIdle;
         default:     state_d = StIdle;
      endcase
   end

   always_comb begin
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      miss_d        = miss_q;
      hit_cnt_d     = hit_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      // The counter wraps to zero after the last word, so each burst starts at word 0.
      cnt_d         = beat ? cnt_q + 1'b1 : cnt_q;

      st_word       = (state_q == StCompare) ? word_offset(addr_q) : cnt_q;
      st_word_we    = 1'b0;
      st_wdata      = wdata_q;
      st_line_we    = 1'b0;
      st_dirty_set  = 1'b0;
      st_dirty_clr  = 1'b0;

      bus.cpu_ready = 1'b0;
      bus.cpu_hit   = 1'b0;
      bus.cpu_rdata = rdata_q;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;

      unique case (state_q)
         StIdle: begin
            if (bus.cpu_req) begin
               we_d    = bus.cpu_we;
               addr_d  = bus.cpu_addr[ADDR_W-1:2];
               wdata_d = bus.cpu_wdata;
               miss_d  = 1'b0;
            end
         end
         StCompare: begin
            if (lookup_hit) begin
               if (we_q) begin
                  st_word_we   = 1'b1;
                  st_dirty_set = 1'b1;
               end else begin
                  rdata_d = st_rdata;
               end
            end else begin
               miss_d = 1'b1;
            end
         end
         StWriteback: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = {st_tag, idx, cnt_q};
            bus.mem_wdata = st_rdata;
            st_dirty_clr  = last_beat;
         end
         StAllocate: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = {tag, idx, cnt_q};
            st_wdata     = bus.mem_rdata;
            st_word_we   = beat;
            st_line_we   = last_beat;
         end
         StResp: begin
            bus.cpu_ready = 1'b1;
            bus.cpu_hit   = !miss_q;
            if (miss_q) begin
               if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
            end else begin
               if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

endmodule
